// File: rtl/mem_probe_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_probe_pkg
// Description : Shared types and default widths for the stride prober.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_probe_pkg;
   localparam int C_ADDR_W  = 20;
   localparam int C_CNT_W   = 16;
   localparam int C_LAT_W   = 16;
   localparam int C_SUM_W   = 32;
   localparam int C_TIMEOUT = 1024;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      REPORT = 2'd2
   } state_e;

   typedef struct packed {
      logic [C_ADDR_W-1:0] base;
      logic [C_ADDR_W-1:0] stride;
      logic [C_CNT_W-1:0]  count;
      logic                write;
      logic [63:0]         wdata;
      logic [7:0]          bytemask;
   } probe_cmd_t;

   typedef struct packed {
      logic [C_LAT_W-1:0] min;
      logic [C_LAT_W-1:0] max;
      logic [C_SUM_W-1:0] total;
      logic [63:0]        rd_xor;
   } probe_res_t;
endpackage
`default_nettype wire

// File: rtl/lat_stats.sv
`default_nettype none
// ============================================================================
// Module      : lat_stats
// Description : Saturating min/max/sum of per-access latency samples.
// Revision    : 1.0 - initial release
// ============================================================================
module lat_stats
   import mem_probe_pkg::*;
#(
   parameter int LAT_W = C_LAT_W,
   parameter int SUM_W = C_SUM_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_sample_valid,
   input  logic [LAT_W-1:0] i_lat,
   output logic [LAT_W-1:0] o_min,
   output logic [LAT_W-1:0] o_max,
   output logic [SUM_W-1:0] o_sum
);
   logic [LAT_W-1:0] r_min;
   logic [LAT_W-1:0] r_max;
   logic [SUM_W-1:0] r_sum;
   logic [SUM_W:0]   w_sum_ext;

   assign w_sum_ext = {1'b0, r_sum} + (SUM_W+1)'(i_lat);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_min <= '0;
         r_max <= '0;
         r_sum <= '0;
      end else if (i_clear) begin
         r_min <= '1;
         r_max <= '0;
         r_sum <= '0;
      end else if (i_sample_valid) begin
         if (i_lat < r_min) r_min <= i_lat;
         if (i_lat > r_max) r_max <= i_lat;
         r_sum <= w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];
      end
   end

   assign o_min = r_min;
   assign o_max = r_max;
   assign o_sum = r_sum;
endmodule
`default_nettype wire

// File: rtl/mem_stride_prober.sv
`default_nettype none
// ============================================================================
// Module      : mem_stride_prober
// Description : Issues strided memory accesses and reports latency statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stride_prober
   import mem_probe_pkg::*;
#(
   parameter int ADDR_W  = C_ADDR_W,
   parameter int CNT_W   = C_CNT_W,
   parameter int LAT_W   = C_LAT_W,
   parameter int SUM_W   = C_SUM_W,
   parameter int TIMEOUT = C_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic [ADDR_W-1:0] cmd_stride,
   input  logic [CNT_W-1:0]  cmd_count,
   input  logic              cmd_write,
   input  logic [63:0]       cmd_wdata,
   input  logic [7:0]        cmd_bytemask,
   output logic              res_done,
   output logic [LAT_W-1:0]  res_min_lat,
   output logic [LAT_W-1:0]  res_max_lat,
   output logic [SUM_W-1:0]  res_total_lat,
   output logic [63:0]       res_rd_xor,
   output logic              err_align,
   output logic              err_timeout,
   output logic [ADDR_W-1:0] address,
   output logic [63:0]       data_in,
   output logic [7:0]        bytemask,
   output logic              write,
   output logic              start_access,
   input  logic              access_done,
   input  logic [63:0]       data_out
);
   state_e            r_state;
   state_e            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_stride;
   logic [CNT_W-1:0]  r_remaining;
   logic [63:0]       r_wdata;
   logic [7:0]        r_bytemask;
   logic              r_write;
   logic              r_start;
   logic [LAT_W-1:0]  r_lat;
   logic [63:0]       r_xor;
   logic              r_empty;
   logic              r_res_done;
   logic              r_err_align;
   logic              r_err_timeout;
   logic              w_accept;
   logic              w_misalign;
   logic              w_done;
   logic              w_last;
   logic [LAT_W-1:0]  w_min;

   assign w_accept   = cmd_valid && (r_state == IDLE);
   assign w_misalign = (|cmd_base[2:0]) || (|cmd_stride[2:0]);
   assign w_done     = r_start && access_done;
   assign w_last     = (r_remaining == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept && !w_misalign)
                     w_next = (cmd_count == '0) ? REPORT : ISSUE;
         ISSUE:   if (w_done && w_last) w_next = REPORT;
         REPORT:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr        <= '0;
         r_stride      <= '0;
         r_remaining   <= '0;
         r_wdata       <= '0;
         r_bytemask    <= '0;
         r_write       <= 1'b0;
         r_start       <= 1'b0;
         r_lat         <= '0;
         r_xor         <= '0;
         r_empty       <= 1'b1;
         r_res_done    <= 1'b0;
         r_err_align   <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         r_res_done  <= (r_state == REPORT);
         r_err_align <= 1'b0;
         if (w_accept) begin
            r_err_timeout <= 1'b0;
            if (w_misalign) begin
               r_err_align <= 1'b1;
            end else begin
               r_addr      <= cmd_base;
               r_stride    <= cmd_stride;
               r_remaining <= cmd_count;
               r_wdata     <= cmd_wdata;
               r_bytemask  <= cmd_bytemask;
               r_write     <= cmd_write;
               r_xor       <= '0;
               r_empty     <= (cmd_count == '0);
               r_lat       <= LAT_W'(1);
               r_start     <= (cmd_count != '0);
            end
         end else if (r_start) begin
            // A stuck access is flagged but never abandoned.
            if (r_lat == LAT_W'(TIMEOUT)) r_err_timeout <= 1'b1;
            if (access_done) begin
               if (!r_write) r_xor <= r_xor ^ data_out;
               r_remaining <= r_remaining - CNT_W'(1);
               if (w_last) begin
                  r_start <= 1'b0;
               end else begin
                  r_addr <= r_addr + r_stride;
                  r_lat  <= LAT_W'(1);
               end
            end else if (r_lat != '1) begin
               r_lat <= r_lat + LAT_W'(1);
            end
         end
      end
   end

   lat_stats #(
      .LAT_W (LAT_W),
      .SUM_W (SUM_W)
   ) u_lat_stats (
      .clk            (clk),
      .reset          (reset),
      .i_clear        (w_accept && !w_misalign),
      .i_sample_valid (w_done),
      .i_lat          (r_lat),
      .o_min          (w_min),
      .o_max          (res_max_lat),
      .o_sum          (res_total_lat)
   );

   // An empty command never sampled anything, so its minimum reads as zero.
   assign res_min_lat  = r_empty ? '0 : w_min;
   assign cmd_ready    = (r_state == IDLE);
   assign res_done     = r_res_done;
   assign res_rd_xor   = r_xor;
   assign err_align    = r_err_align;
   assign err_timeout  = r_err_timeout;
   assign address      = r_addr;
   assign data_in      = r_wdata;
   assign bytemask     = r_bytemask;
   assign write        = r_write;
   assign start_access = r_start;
endmodule
`default_nettype wire

// File: tb/tb_mem_stride_prober.sv
`default_nettype none
// Bench for mem_stride_prober: a latency-programmable responder feeds a
// queue-based model of addresses, latencies and read data.
module tb_mem_stride_prober;
   logic        clk = 0;
   logic        reset = 1;
   logic        cmd_valid = 0;
   logic        cmd_ready;
   logic [19:0] cmd_base = 0, cmd_stride = 0;
   logic [15:0] cmd_count = 0;
   logic        cmd_write = 0;
   logic [63:0] cmd_wdata = 0;
   logic [7:0]  cmd_bytemask = 0;
   logic        res_done;
   logic [15:0] res_min_lat, res_max_lat;
   logic [31:0] res_total_lat;
   logic [63:0] res_rd_xor;
   logic        err_align, err_timeout;
   logic [19:0] address;
   logic [63:0] data_in;
   logic [7:0]  bytemask;
   logic        write, start_access;
   logic        access_done = 0;
   logic [63:0] data_out = 0;

   int n_tests = 0;
   int n_fail  = 0;

   int lat_mode = 0;   // 0: fixed latency fix_lat, 1: random 1..8
   int fix_lat  = 5;
   int stab_err = 0;
   logic [19:0] q_addr[$];
   logic [63:0] q_wd[$], q_rd[$];
   logic [7:0]  q_bm[$];
   logic        q_wr[$];
   int          q_lat[$];

   always #5 clk = ~clk;

   mem_stride_prober dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_count(cmd_count),
      .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_bytemask(cmd_bytemask),
      .res_done(res_done), .res_min_lat(res_min_lat), .res_max_lat(res_max_lat),
      .res_total_lat(res_total_lat), .res_rd_xor(res_rd_xor),
      .err_align(err_align), .err_timeout(err_timeout), .address(address),
      .data_in(data_in), .bytemask(bytemask), .write(write),
      .start_access(start_access), .access_done(access_done), .data_out(data_out)
   );

   // Memory responder: completes each request after the chosen number of cycles.
   initial begin
      int cnt, cur;
      cnt = 0; cur = 1;
      forever begin
         @(negedge clk);
         if (access_done) begin access_done = 0; cnt = 0; end
         if (reset) begin
            access_done = 0; cnt = 0;
         end else if (start_access) begin
            cnt++;
            if (cnt == 1) begin
               cur = (lat_mode == 0) ? fix_lat : int'($urandom_range(1, 8));
               q_lat.push_back(cur);
               q_addr.push_back(address); q_wd.push_back(data_in);
               q_bm.push_back(bytemask);  q_wr.push_back(write);
            end else if (address !== q_addr[$] || data_in !== q_wd[$] ||
                         bytemask !== q_bm[$] || write !== q_wr[$]) begin
               stab_err++;
            end
            if (cnt == cur) begin
               access_done = 1;
               data_out = {$urandom, $urandom};
               q_rd.push_back(data_out);
            end
         end else begin
            cnt = 0;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk); reset = 1;
      repeat (3) @(negedge clk);
      reset = 0;
   endtask

   // Drives one command and observes the run; k counts negedges after the accept edge.
   task automatic run_cmd(input logic [19:0] b, input logic [19:0] s, input logic [15:0] c,
                          input logic w, input logic [63:0] wd, input logic [7:0] bm,
                          input int budget, output int done_k, output int n_done,
                          output int start_cyc, output int tmo_k, output int align_k,
                          output int ready_low);
      q_addr.delete(); q_wd.delete(); q_rd.delete(); q_bm.delete(); q_wr.delete(); q_lat.delete();
      stab_err = 0;
      done_k = -1; n_done = 0; start_cyc = 0; tmo_k = -1; align_k = -1; ready_low = 0;
      @(negedge clk);
      cmd_base = b; cmd_stride = s; cmd_count = c; cmd_write = w;
      cmd_wdata = wd; cmd_bytemask = bm; cmd_valid = 1;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         cmd_valid = 0;
         if (start_access) start_cyc++;
         if (res_done) begin n_done++; if (done_k < 0) done_k = k; end
         if (err_timeout && tmo_k < 0) tmo_k = k;
         if (err_align && align_k < 0) align_k = k;
         if (!cmd_ready) ready_low++;
         if (done_k > 0 && k >= done_k + 3) break;
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", cmd_ready); end
      n_tests++; if ({start_access, write, res_done, err_align, err_timeout} !== 5'b0) begin n_fail++;
         $display("FAIL reset_flags: got %b expected 00000", {start_access, write, res_done, err_align, err_timeout}); end
      n_tests++; if ({res_min_lat, res_max_lat, res_total_lat} !== 64'd0 || res_rd_xor !== 64'd0) begin n_fail++;
         $display("FAIL reset_results: got min %0d max %0d tot %0d xor %0h expected all 0", res_min_lat, res_max_lat, res_total_lat, res_rd_xor); end
      n_tests++; if (address !== 20'd0 || data_in !== 64'd0 || bytemask !== 8'd0) begin n_fail++;
         $display("FAIL reset_mem: got addr %0h data %0h mask %0h expected 0", address, data_in, bytemask); end
   endtask

   task automatic test_fixed_read();
      int dk, nd, sc, tk, ak, rl;
      logic [63:0] ex;
      lat_mode = 0; fix_lat = 5;
      run_cmd(20'h0, 20'h8, 16'd4, 1'b0, 64'h0, 8'hFF, 60, dk, nd, sc, tk, ak, rl);
      n_tests++; if (q_addr.size() != 4) begin n_fail++; $display("FAIL fixed_nacc: got %0d expected 4", q_addr.size()); end
      for (int i = 0; i < q_addr.size() && i < 4; i++) begin
         n_tests++; if (q_addr[i] !== 20'(i * 8)) begin n_fail++; $display("FAIL fixed_addr%0d: got %0h expected %0h", i, q_addr[i], i * 8); end
      end
      n_tests++; if (res_min_lat !== 16'd5 || res_max_lat !== 16'd5) begin n_fail++;
         $display("FAIL fixed_minmax: got %0d/%0d expected 5/5", res_min_lat, res_max_lat); end
      n_tests++; if (res_total_lat !== 32'd20) begin n_fail++; $display("FAIL fixed_total: got %0d expected 20", res_total_lat); end
      n_tests++; if (nd != 1 || dk != 22) begin n_fail++; $display("FAIL fixed_done: got %0d pulses at %0d expected 1 at 22", nd, dk); end
      n_tests++; if (sc != 20) begin n_fail++; $display("FAIL fixed_b2b: got %0d start cycles expected 20", sc); end
      ex = 0; foreach (q_rd[i]) ex ^= q_rd[i];
      n_tests++; if (res_rd_xor !== ex) begin n_fail++; $display("FAIL fixed_xor: got %0h expected %0h", res_rd_xor, ex); end
      n_tests++; if (stab_err != 0) begin n_fail++; $display("FAIL fixed_stable: got %0d unstable cycles expected 0", stab_err); end
   endtask

   task automatic test_align();
      int dk, nd, sc, tk, ak, rl;
      logic [19:0] bases[2] = '{20'h4, 20'h10};
      logic [19:0] strides[2] = '{20'h8, 20'h3};
      for (int i = 0; i < 2; i++) begin
         run_cmd(bases[i], strides[i], 16'd3, 1'b0, 64'h0, 8'hFF, 8, dk, nd, sc, tk, ak, rl);
         n_tests++; if (ak != 1) begin n_fail++; $display("FAIL align%0d_pulse: got first at %0d expected 1", i, ak); end
         n_tests++; if (err_align !== 1'b0) begin n_fail++; $display("FAIL align%0d_width: got %0b expected 0", i, err_align); end
         n_tests++; if (sc != 0 || nd != 0 || rl != 0) begin n_fail++;
            $display("FAIL align%0d_quiet: got start %0d done %0d notready %0d expected 0", i, sc, nd, rl); end
      end
   endtask

   task automatic test_zero_count();
      int dk, nd, sc, tk, ak, rl;
      run_cmd(20'h100, 20'h8, 16'd0, 1'b0, 64'h0, 8'hFF, 20, dk, nd, sc, tk, ak, rl);
      n_tests++; if (dk != 2 || nd != 1) begin n_fail++; $display("FAIL zero_done: got at %0d x%0d expected at 2 x1", dk, nd); end
      n_tests++; if (sc != 0) begin n_fail++; $display("FAIL zero_noacc: got %0d start cycles expected 0", sc); end
      n_tests++; if (res_min_lat !== 0 || res_max_lat !== 0 || res_total_lat !== 0 || res_rd_xor !== 0) begin n_fail++;
         $display("FAIL zero_results: got %0d %0d %0d %0h expected 0", res_min_lat, res_max_lat, res_total_lat, res_rd_xor); end
   endtask

   task automatic test_wrap_write();
      int dk, nd, sc, tk, ak, rl;
      logic [63:0] wd;
      lat_mode = 0; fix_lat = 3;
      wd = {$urandom, $urandom};
      run_cmd(20'hFFFF8, 20'h8, 16'd2, 1'b1, wd, 8'h0F, 30, dk, nd, sc, tk, ak, rl);
      n_tests++; if (q_addr.size() != 2 || q_addr[0] !== 20'hFFFF8 || q_addr[1] !== 20'h00000) begin n_fail++;
         $display("FAIL wrap_addr: got %0d accesses first %0h expected FFFF8 then 0", q_addr.size(), q_addr.size() ? q_addr[0] : 20'h0); end
      for (int i = 0; i < q_wd.size(); i++) begin
         n_tests++; if (q_wd[i] !== wd || q_bm[i] !== 8'h0F || q_wr[i] !== 1'b1) begin n_fail++;
            $display("FAIL wrap_wdata%0d: got %0h/%0h/%0b expected %0h/0f/1", i, q_wd[i], q_bm[i], q_wr[i], wd); end
      end
      n_tests++; if (stab_err != 0) begin n_fail++; $display("FAIL wrap_stable: got %0d expected 0", stab_err); end
      n_tests++; if (res_rd_xor !== 64'd0 || res_total_lat !== 32'd6) begin n_fail++;
         $display("FAIL wrap_results: got xor %0h total %0d expected 0 and 6", res_rd_xor, res_total_lat); end
   endtask

   task automatic test_random();
      int dk, nd, sc, tk, ak, rl;
      logic [19:0] b, s, ea;
      logic [15:0] c;
      logic        w;
      int emin, emax, esum;
      logic [63:0] ex;
      lat_mode = 1;
      for (int it = 0; it < 8; it++) begin
         b = {17'($urandom), 3'b000};
         s = {17'($urandom), 3'b000};
         c = 16'($urandom_range(1, 6));
         w = 1'($urandom);
         run_cmd(b, s, c, w, {$urandom, $urandom}, 8'($urandom), 80, dk, nd, sc, tk, ak, rl);
         emin = 1 << 30; emax = 0; esum = 0; ex = 0;
         foreach (q_lat[i]) begin
            if (q_lat[i] < emin) emin = q_lat[i];
            if (q_lat[i] > emax) emax = q_lat[i];
            esum += q_lat[i];
         end
         if (!w) foreach (q_rd[i]) ex ^= q_rd[i];
         ea = b;
         n_tests++; if (q_addr.size() != int'(c)) begin n_fail++; $display("FAIL rnd%0d_nacc: got %0d expected %0d", it, q_addr.size(), c); end
         for (int i = 0; i < q_addr.size(); i++) begin
            n_tests++; if (q_addr[i] !== ea) begin n_fail++; $display("FAIL rnd%0d_addr%0d: got %0h expected %0h", it, i, q_addr[i], ea); end
            ea = ea + s;
         end
         n_tests++; if (int'(res_min_lat) != emin || int'(res_max_lat) != emax || int'(res_total_lat) != esum) begin n_fail++;
            $display("FAIL rnd%0d_stats: got %0d/%0d/%0d expected %0d/%0d/%0d", it, res_min_lat, res_max_lat, res_total_lat, emin, emax, esum); end
         n_tests++; if (res_rd_xor !== ex) begin n_fail++; $display("FAIL rnd%0d_xor: got %0h expected %0h", it, res_rd_xor, ex); end
         n_tests++; if (dk != esum + 2 || nd != 1 || sc != esum || stab_err != 0) begin n_fail++;
            $display("FAIL rnd%0d_timing: got done %0d x%0d start %0d unstable %0d expected %0d x1 %0d 0", it, dk, nd, sc, stab_err, esum + 2, esum); end
      end
   endtask

   task automatic test_reset_mid();
      lat_mode = 0; fix_lat = 50;
      @(negedge clk);
      cmd_base = 20'h40; cmd_stride = 20'h8; cmd_count = 16'd3; cmd_write = 1'b0; cmd_valid = 1;
      @(negedge clk); cmd_valid = 0;
      repeat (9) @(negedge clk);
      n_tests++; if (start_access !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++;
         $display("FAIL rstmid_busy: got start %0b ready %0b expected 1 0", start_access, cmd_ready); end
      reset = 1;
      @(negedge clk);
      n_tests++; if (start_access !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++;
         $display("FAIL rstmid_drop: got start %0b ready %0b expected 0 1", start_access, cmd_ready); end
      reset = 0;
      repeat (3) @(negedge clk);
      n_tests++; if (start_access !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got %0b expected 0", start_access); end
   endtask

   task automatic test_timeout();
      int dk, nd, sc, tk, ak, rl;
      lat_mode = 0; fix_lat = 2000;
      run_cmd(20'h0, 20'h8, 16'd1, 1'b0, 64'h0, 8'hFF, 2100, dk, nd, sc, tk, ak, rl);
      n_tests++; if (tk != 1025) begin n_fail++; $display("FAIL tmo_set: got first at %0d expected 1025", tk); end
      n_tests++; if (nd != 1 || dk != 2002 || res_max_lat !== 16'd2000) begin n_fail++;
         $display("FAIL tmo_complete: got done %0d x%0d lat %0d expected 2002 x1 2000", dk, nd, res_max_lat); end
      n_tests++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %0b expected 1", err_timeout); end
      fix_lat = 2;
      run_cmd(20'h0, 20'h8, 16'd1, 1'b0, 64'h0, 8'hFF, 20, dk, nd, sc, tk, ak, rl);
      n_tests++; if (tk != -1) begin n_fail++; $display("FAIL tmo_clear: got set at %0d expected never", tk); end
   endtask

   initial begin
      test_reset();
      test_fixed_read();
      test_align();
      test_zero_count();
      test_wrap_write();
      test_random();
      test_reset_mid();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
